// File: rtl/exe_operand_stage.sv
// ID/EX register with operand forwarding/select feeding the ALU.
// Optional macro EXE_FWD_EN: enables EX/MEM and MEM/WB forwarding; without it any hit stalls.
// state | meaning
// EMPTY | r_valid=0, nothing held, in_ready=1
// FULL  | r_valid=1, operands presented to the ALU
module exe_operand_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs_addr,
    input  logic [REG_ADDR_W-1:0] in_rt_addr,
    input  logic [REG_ADDR_W-1:0] in_dest_addr,
    input  logic [DATA_W-1:0]     in_rs_data,
    input  logic [DATA_W-1:0]     in_rt_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [4:0]            in_shamt,
    input  logic [4:0]            in_alu_op,
    input  logic                  in_use_imm,
    input  logic                  in_use_shamt,
    input  logic                  in_reg_write,
    input  logic                  in_is_load,
    input  logic                  flush,
    input  logic                  exm_valid,
    input  logic                  exm_reg_write,
    input  logic                  exm_is_load,
    input  logic [REG_ADDR_W-1:0] exm_dest,
    input  logic [DATA_W-1:0]     exm_result,
    input  logic                  mwb_valid,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_dest,
    input  logic [DATA_W-1:0]     mwb_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [4:0]            alu_op,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  out_reg_write,
    output logic                  out_is_load
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_rs_addr;
    logic [REG_ADDR_W-1:0] r_rt_addr;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [DATA_W-1:0]     r_imm;
    logic [4:0]            r_shamt;
    logic [4:0]            r_alu_op;
    logic                  r_use_imm;
    logic                  r_use_shamt;
    logic                  r_reg_write;
    logic                  r_is_load;

    logic                  w_exm_rs;
    logic                  w_exm_rt;
    logic                  w_mwb_rs;
    logic                  w_mwb_rt;
    logic                  w_rs_used;
    logic                  w_hazard;
    logic                  w_fire;
    logic                  w_capture;
    logic [DATA_W-1:0]     w_fwd_rs;
    logic [DATA_W-1:0]     w_fwd_rt;

    assign w_exm_rs  = exm_valid && exm_reg_write && (exm_dest == r_rs_addr) && (r_rs_addr != '0);
    assign w_exm_rt  = exm_valid && exm_reg_write && (exm_dest == r_rt_addr) && (r_rt_addr != '0);
    assign w_mwb_rs  = mwb_valid && mwb_reg_write && (mwb_dest == r_rs_addr) && (r_rs_addr != '0);
    assign w_mwb_rt  = mwb_valid && mwb_reg_write && (mwb_dest == r_rt_addr) && (r_rt_addr != '0);
    // rt is treated as always used so store-type ops never need an opcode decode here
    assign w_rs_used = !r_use_shamt;

`ifdef EXE_FWD_EN
    assign w_hazard = exm_is_load && ((w_rs_used && w_exm_rs) || w_exm_rt);
    assign w_fwd_rs = w_exm_rs ? exm_result : (w_mwb_rs ? mwb_result : r_rs_data);
    assign w_fwd_rt = w_exm_rt ? exm_result : (w_mwb_rt ? mwb_result : r_rt_data);
`else
    logic w_unused_results;
    assign w_unused_results = ^{exm_result, mwb_result, exm_is_load};
    assign w_hazard = (w_rs_used && (w_exm_rs || w_mwb_rs)) || w_exm_rt || w_mwb_rt;
    assign w_fwd_rs = r_rs_data;
    assign w_fwd_rt = r_rt_data;
`endif

    assign out_valid     = (r_valid == ST_FULL) && !w_hazard;
    assign w_fire        = out_valid && out_ready;
    assign in_ready      = (r_valid == ST_EMPTY) || w_fire;
    assign w_capture     = in_valid && in_ready && !flush;

    assign alu_a         = r_use_shamt ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
    assign alu_b         = r_use_imm ? r_imm : w_fwd_rt;
    assign alu_op        = r_alu_op;
    assign out_dest      = r_dest;
    assign out_reg_write = r_reg_write;
    assign out_is_load   = r_is_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= ST_EMPTY;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_dest      <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
            r_alu_op    <= '0;
            r_use_imm   <= 1'b0;
            r_use_shamt <= 1'b0;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
        end else begin
            if (flush)
                r_valid <= ST_EMPTY;
            else if (w_capture)
                r_valid <= ST_FULL;
            else if (w_fire)
                r_valid <= ST_EMPTY;

            if (w_capture) begin
                r_rs_addr   <= in_rs_addr;
                r_rt_addr   <= in_rt_addr;
                r_dest      <= in_dest_addr;
                r_rs_data   <= in_rs_data;
                r_rt_data   <= in_rt_data;
                r_imm       <= in_imm;
                r_shamt     <= in_shamt;
                r_alu_op    <= in_alu_op;
                r_use_imm   <= in_use_imm;
                r_use_shamt <= in_use_shamt;
                r_reg_write <= in_reg_write;
                r_is_load   <= in_is_load;
            end
        end
    end

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed bench for exe_operand_stage; expectations follow the EXE_FWD_EN build setting.
module tb_exe_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs_addr, in_rt_addr, in_dest_addr;
    logic [31:0] in_rs_data, in_rt_data, in_imm;
    logic [4:0]  in_shamt, in_alu_op;
    logic        in_use_imm, in_use_shamt, in_reg_write, in_is_load;
    logic        flush;
    logic        exm_valid, exm_reg_write, exm_is_load;
    logic [4:0]  exm_dest;
    logic [31:0] exm_result;
    logic        mwb_valid, mwb_reg_write;
    logic [4:0]  mwb_dest;
    logic [31:0] mwb_result;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op, out_dest;
    logic        out_reg_write, out_is_load;

    int checks = 0;
    int errors = 0;

    exe_operand_stage #(.REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_dest_addr(in_dest_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_alu_op(in_alu_op),
        .in_use_imm(in_use_imm), .in_use_shamt(in_use_shamt),
        .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .flush(flush),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
        .exm_dest(exm_dest), .exm_result(exm_result),
        .mwb_valid(mwb_valid), .mwb_reg_write(mwb_reg_write),
        .mwb_dest(mwb_dest), .mwb_result(mwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .out_dest(out_dest), .out_reg_write(out_reg_write), .out_is_load(out_is_load)
    );

    always #5 clk = ~clk;

`ifdef EXE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        in_valid = 0; in_rs_addr = 0; in_rt_addr = 0; in_dest_addr = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_shamt = 0; in_alu_op = 0;
        in_use_imm = 0; in_use_shamt = 0; in_reg_write = 0; in_is_load = 0;
        flush = 0; out_ready = 0;
        exm_valid = 0; exm_reg_write = 0; exm_is_load = 0; exm_dest = 0; exm_result = 0;
        mwb_valid = 0; mwb_reg_write = 0; mwb_dest = 0; mwb_result = 0;
    endtask

    // Presents one instruction with out_ready=1 so a held one drains in the same cycle.
    task automatic issue(input logic [4:0] rs_a, input logic [4:0] rt_a, input logic [4:0] dst,
                         input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                         input logic [4:0] sh, input logic [4:0] op,
                         input logic uimm, input logic ush);
        in_valid = 1; in_rs_addr = rs_a; in_rt_addr = rt_a; in_dest_addr = dst;
        in_rs_data = rs_d; in_rt_data = rt_d; in_imm = imm; in_shamt = sh; in_alu_op = op;
        in_use_imm = uimm; in_use_shamt = ush; in_reg_write = 1; in_is_load = 0;
        out_ready = 1;
        tick();
        in_valid = 0; out_ready = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clr_inputs();
        #2;
        checks++; if (out_valid !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: out_valid=%b alu_a=%h alu_b=%h expected 0 0 0", out_valid, alu_a, alu_b); end
        tick(); tick();
        rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        issue(5'd1, 5'd0, 5'd9, 32'h1234, 32'h0, 32'h5, 5'd0, 5'd3, 1'b1, 1'b0);
        in_is_load = 0;
        checks++; if (out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_prefull: out_valid=%b expected 1", out_valid); end
        #3 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 5'd0 ||
                      out_dest !== 5'd0 || out_reg_write !== 1'b0 || out_is_load !== 1'b0) begin
            errors++; $display("FAIL reset_midfull: v=%b a=%h b=%h op=%h d=%h rw=%b ld=%b expected all 0",
                               out_valid, alu_a, alu_b, alu_op, out_dest, out_reg_write, out_is_load); end
        tick();
        rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
    endtask

    task automatic test_capture();
        issue(5'd1, 5'd0, 5'd2, 32'd5, 32'd0, 32'd7, 5'd0, 5'd1, 1'b1, 1'b0);
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || out_valid !== 1'b1) begin
            errors++; $display("FAIL capture_add: a=%h b=%h v=%b expected 5 7 1", alu_a, alu_b, out_valid); end
        checks++; if (alu_op !== 5'd1 || out_dest !== 5'd2 || out_reg_write !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL capture_fields: op=%h dest=%h rw=%b in_ready=%b expected 1 2 1 0",
                               alu_op, out_dest, out_reg_write, in_ready); end
    endtask

    task automatic test_forward();
        issue(5'd3, 5'd0, 5'd7, 32'h99, 32'h0, 32'h1, 5'd0, 5'd1, 1'b1, 1'b0);
        exm_valid = 1; exm_reg_write = 1; exm_dest = 5'd3; exm_result = 32'h10;
        mwb_valid = 1; mwb_reg_write = 1; mwb_dest = 5'd3; mwb_result = 32'h20;
        #1;
        checks++; if (alu_a !== (FWD ? 32'h10 : 32'h99) || out_valid !== FWD || in_ready !== 1'b0) begin
            errors++; $display("FAIL fwd_exm_priority: a=%h v=%b rdy=%b expected %h %b 0",
                               alu_a, out_valid, in_ready, FWD ? 32'h10 : 32'h99, FWD); end
        exm_valid = 0;
        #1;
        checks++; if (alu_a !== (FWD ? 32'h20 : 32'h99) || out_valid !== FWD) begin
            errors++; $display("FAIL fwd_mwb: a=%h v=%b expected %h %b", alu_a, out_valid, FWD ? 32'h20 : 32'h99, FWD); end
        mwb_valid = 0;
        #1;
        checks++; if (alu_a !== 32'h99 || out_valid !== 1'b1) begin
            errors++; $display("FAIL fwd_none: a=%h v=%b expected 99 1", alu_a, out_valid); end
        issue(5'd0, 5'd0, 5'd7, 32'h55, 32'h0, 32'h1, 5'd0, 5'd1, 1'b1, 1'b0);
        exm_valid = 1; exm_reg_write = 1; exm_dest = 5'd0; exm_result = 32'h10;
        mwb_valid = 1; mwb_reg_write = 1; mwb_dest = 5'd0; mwb_result = 32'h20;
        #1;
        checks++; if (alu_a !== 32'h55 || out_valid !== 1'b1) begin
            errors++; $display("FAIL fwd_reg0: a=%h v=%b expected 55 1", alu_a, out_valid); end
        clr_inputs();
    endtask

    task automatic test_load_use();
        issue(5'd0, 5'd4, 5'd8, 32'h2, 32'h11, 32'h0, 5'd0, 5'd2, 1'b0, 1'b0);
        exm_valid = 1; exm_reg_write = 1; exm_is_load = 1; exm_dest = 5'd4; exm_result = 32'hDEAD;
        out_ready = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL loaduse_stall: v=%b rdy=%b expected 0 0", out_valid, in_ready); end
        tick();
        exm_valid = 0; exm_is_load = 0;
        mwb_valid = 1; mwb_reg_write = 1; mwb_dest = 5'd4; mwb_result = 32'hAB;
        #1;
        checks++; if (out_valid !== FWD || (FWD && alu_b !== 32'hAB) || (!FWD && alu_b !== 32'h11)) begin
            errors++; $display("FAIL loaduse_mwb: v=%b b=%h expected %b %h", out_valid, alu_b, FWD, FWD ? 32'hAB : 32'h11); end
        checks++; if (alu_a !== 32'h2) begin
            errors++; $display("FAIL loaduse_rs0: a=%h expected 2", alu_a); end
        tick();
        mwb_valid = 0;
        #1;
        checks++; if (FWD ? (out_valid !== 1'b0) : (out_valid !== 1'b1 || alu_b !== 32'h11)) begin
            errors++; $display("FAIL loaduse_after: v=%b b=%h expected %b 11", out_valid, alu_b, !FWD); end
        tick();
        clr_inputs();
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL loaduse_drain: v=%b rdy=%b expected 0 1", out_valid, in_ready); end
    endtask

    task automatic test_shift_hold();
        issue(5'd6, 5'd5, 5'd10, 32'h77, 32'h1, 32'h0, 5'd4, 5'd4, 1'b0, 1'b1);
        in_valid = 1; in_rs_data = 32'hFFFF; in_rt_data = 32'hEEEE; in_shamt = 5'd9;
        for (int i = 0; i < 3; i++) begin
            checks++; if (alu_a !== 32'd4 || alu_b !== 32'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL sll_hold%0d: a=%h b=%h v=%b rdy=%b expected 4 1 1 0",
                                   i, alu_a, alu_b, out_valid, in_ready); end
            tick();
        end
        in_valid = 0; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL sll_fire_ready: got %b expected 1", in_ready); end
        tick();
        out_ready = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL sll_empty: v=%b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        issue(5'd1, 5'd0, 5'd2, 32'hA1, 32'h0, 32'h0, 5'd0, 5'd1, 1'b0, 1'b0);
        issue(5'd1, 5'd0, 5'd3, 32'hB2, 32'h0, 32'h0, 5'd0, 5'd1, 1'b0, 1'b0);
        checks++; if (alu_a !== 32'hB2 || out_dest !== 5'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_second: a=%h dest=%h v=%b expected b2 3 1", alu_a, out_dest, out_valid); end
    endtask

    task automatic test_flush();
        in_valid = 1; in_rs_data = 32'hC3; in_rs_addr = 5'd1; flush = 1; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 0; flush = 0; out_ready = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_capture: v=%b expected 0", out_valid); end
        issue(5'd2, 5'd6, 5'd1, 32'h1, 32'h2, 32'h0, 5'd0, 5'd1, 1'b0, 1'b0);
        exm_valid = 1; exm_reg_write = 1; exm_is_load = 1; exm_dest = 5'd6;
        flush = 1;
        tick();
        flush = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_stall: v=%b rdy=%b expected 0 1", out_valid, in_ready); end
        clr_inputs();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_shift_hold();
        test_back_to_back();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
